// File: rtl/tmr_fault_injector_if.sv
// Campaign request channel of the TMR fault injector.
// The master (test controller) posts one campaign descriptor at a time.
// The slave (injector) takes it when cfg_valid_i and cfg_ready_o are both high.
interface tmr_fault_injector_if #(
   parameter int WIDTH = 32
);
   localparam int BIT_W = $clog2(WIDTH);

   logic             cfg_valid_i;
   logic             cfg_ready_o;
   logic [1:0]       cfg_target_i;
   logic [BIT_W-1:0] cfg_bit_i;
   logic [15:0]      cfg_delay_i;
   logic [7:0]       cfg_duration_i;

   modport master (
      output cfg_valid_i, cfg_target_i, cfg_bit_i, cfg_delay_i, cfg_duration_i,
      input  cfg_ready_o
   );

   modport slave (
      input  cfg_valid_i, cfg_target_i, cfg_bit_i, cfg_delay_i, cfg_duration_i,
      output cfg_ready_o
   );
endinterface

// File: rtl/tmr_fault_injector.sv
// TMR fault injector: flips one bit of one replica result for a programmed
// window, then watches the voter flags to decide whether the fault was caught.
// Replica results pass through combinationally, so the voter sees no extra latency.
// The XOR mask is decoded from the state register. A reset or an abort
// therefore removes the corruption in the same cycle.
module tmr_fault_injector #(
   parameter int          WIDTH   = 32,
   parameter int          TIMEOUT = 8,
   parameter logic [15:0] SEED    = 16'hACE1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   tmr_fault_injector_if.slave  cfg,
   input  logic                 abort_i,
   input  logic [WIDTH-1:0]     result_A_i,
   input  logic [WIDTH-1:0]     result_B_i,
   input  logic [WIDTH-1:0]     result_C_i,
   output logic [WIDTH-1:0]     result_A_o,
   output logic [WIDTH-1:0]     result_B_o,
   output logic [WIDTH-1:0]     result_C_o,
   input  logic                 fault_A_i,
   input  logic                 fault_B_i,
   input  logic                 fault_C_i,
   input  logic                 system_fault_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 detected_o,
   output logic                 missed_o,
   output logic                 collateral_o,
   output logic [15:0]          inject_count_o,
   output logic [15:0]          detect_count_o,
   output logic [15:0]          miss_count_o
);

   localparam int BIT_W = $clog2(WIDTH);
   localparam int OBS_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT    = 3'd1,
      ST_INJECT  = 3'd2,
      ST_OBSERVE = 3'd3,
      ST_REPORT  = 3'd4
   } state_t;

   // Statistics counters stick at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t            state_r, state_nxt_s;
   logic [15:0]       lfsr_r;
   logic [1:0]        tgt_r, tgt_sel_s;
   logic [BIT_W-1:0]  bit_r;
   logic [15:0]       delay_cnt_r;
   logic [7:0]        dur_cnt_r;
   logic [OBS_W-1:0]  obs_cnt_r;
   logic              detected_r, missed_r, collateral_r;
   logic [15:0]       inject_count_r, detect_count_r, miss_count_r;
   logic              accept_s, watch_s, inj_active_s;
   logic              tgt_flag_s, other_flag_s;
   logic              detected_nxt_s, collateral_nxt_s;
   logic              inject_entry_s, report_entry_s;
   logic [WIDTH-1:0]  mask_s;

   assign accept_s       = cfg.cfg_valid_i && (state_r == ST_IDLE);
   assign watch_s        = (state_r == ST_INJECT) || (state_r == ST_OBSERVE);
   assign inj_active_s   = (state_r == ST_INJECT) && !abort_i;
   assign mask_s         = {{(WIDTH-1){1'b0}}, 1'b1} << bit_r;
   assign inject_entry_s = (state_nxt_s == ST_INJECT) && (state_r != ST_INJECT);
   assign report_entry_s = (state_r == ST_OBSERVE) && (state_nxt_s == ST_REPORT);

   assign cfg.cfg_ready_o = (state_r == ST_IDLE);
   assign busy_o          = (state_r != ST_IDLE);
   assign done_o          = (state_r == ST_REPORT);
   assign detected_o      = detected_r;
   assign missed_o        = missed_r;
   assign collateral_o    = collateral_r;
   assign inject_count_o  = inject_count_r;
   assign detect_count_o  = detect_count_r;
   assign miss_count_o    = miss_count_r;

   // Resolve the replica to hit; a random request uses the LFSR value of the accept cycle.
   always_comb begin
      tgt_sel_s = cfg.cfg_target_i;
      if (cfg.cfg_target_i == 2'd3) begin
         case (lfsr_r[1:0])
            2'd0:    tgt_sel_s = 2'd0;
            2'd1:    tgt_sel_s = 2'd1;
            default: tgt_sel_s = 2'd2;
         endcase
      end else begin
         tgt_sel_s = cfg.cfg_target_i;
      end
   end

   // Split the voter flags into the flag of the hit replica and everything else.
   always_comb begin
      tgt_flag_s   = 1'b0;
      other_flag_s = system_fault_i;
      case (tgt_r)
         2'd0: begin
            tgt_flag_s   = fault_A_i;
            other_flag_s = system_fault_i | fault_B_i | fault_C_i;
         end
         2'd1: begin
            tgt_flag_s   = fault_B_i;
            other_flag_s = system_fault_i | fault_A_i | fault_C_i;
         end
         2'd2: begin
            tgt_flag_s   = fault_C_i;
            other_flag_s = system_fault_i | fault_A_i | fault_B_i;
         end
         default: begin
            tgt_flag_s   = 1'b0;
            other_flag_s = system_fault_i;
         end
      endcase
      detected_nxt_s   = detected_r   | (watch_s & tgt_flag_s);
      collateral_nxt_s = collateral_r | (watch_s & other_flag_s);
   end

   // Pass-through datapath with the bit flip applied only to the selected replica while injecting.
   always_comb begin
      result_A_o = result_A_i;
      result_B_o = result_B_i;
      result_C_o = result_C_i;
      if (inj_active_s) begin
         case (tgt_r)
            2'd0:    result_A_o = result_A_i ^ mask_s;
            2'd1:    result_B_o = result_B_i ^ mask_s;
            2'd2:    result_C_o = result_C_i ^ mask_s;
            default: result_A_o = result_A_i;
         endcase
      end else begin
         result_A_o = result_A_i;
      end
   end

   // Campaign sequencing; a zero delay skips WAIT so the flip lands right after the accept cycle.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               if (cfg.cfg_delay_i == 16'd0) begin
                  state_nxt_s = ST_INJECT;
               end else begin
                  state_nxt_s = ST_WAIT;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (abort_i) begin
               state_nxt_s = ST_IDLE;
            end else if (delay_cnt_r == 16'd0) begin
               state_nxt_s = ST_INJECT;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_INJECT: begin
            if (abort_i) begin
               state_nxt_s = ST_IDLE;
            end else if (dur_cnt_r == 8'd1) begin
               state_nxt_s = ST_OBSERVE;
            end else begin
               state_nxt_s = ST_INJECT;
            end
         end
         ST_OBSERVE: begin
            if (abort_i) begin
               state_nxt_s = ST_IDLE;
            end else if (detected_r || (obs_cnt_r == OBS_W'(TIMEOUT - 1))) begin
               state_nxt_s = ST_REPORT;
            end else begin
               state_nxt_s = ST_OBSERVE;
            end
         end
         ST_REPORT: state_nxt_s = ST_IDLE;
         default:   state_nxt_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Free-running Fibonacci LFSR (taps 16,14,13,11) for random replica selection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lfsr_r <= SEED;
      end else begin
         lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
      end
   end

   // Campaign descriptor, phase counters and sticky per-campaign status.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tgt_r        <= 2'd0;
         bit_r        <= {BIT_W{1'b0}};
         delay_cnt_r  <= 16'd0;
         dur_cnt_r    <= 8'd0;
         obs_cnt_r    <= {OBS_W{1'b0}};
         detected_r   <= 1'b0;
         missed_r     <= 1'b0;
         collateral_r <= 1'b0;
      end else if (accept_s) begin
         tgt_r        <= tgt_sel_s;
         bit_r        <= cfg.cfg_bit_i;
         // WAIT is entered one cycle after accept, so it counts one cycle less than requested.
         delay_cnt_r  <= (cfg.cfg_delay_i == 16'd0) ? 16'd0 : cfg.cfg_delay_i - 16'd1;
         dur_cnt_r    <= (cfg.cfg_duration_i == 8'd0) ? 8'd1 : cfg.cfg_duration_i;
         obs_cnt_r    <= {OBS_W{1'b0}};
         detected_r   <= 1'b0;
         missed_r     <= 1'b0;
         collateral_r <= 1'b0;
      end else begin
         detected_r   <= detected_nxt_s;
         collateral_r <= collateral_nxt_s;
         if ((state_r == ST_WAIT) && (delay_cnt_r != 16'd0)) begin
            delay_cnt_r <= delay_cnt_r - 16'd1;
         end
         if ((state_r == ST_INJECT) && (dur_cnt_r != 8'd1)) begin
            dur_cnt_r <= dur_cnt_r - 8'd1;
         end
         if (state_r == ST_OBSERVE) begin
            obs_cnt_r <= obs_cnt_r + {{(OBS_W-1){1'b0}}, 1'b1};
         end else begin
            obs_cnt_r <= {OBS_W{1'b0}};
         end
         if (report_entry_s) begin
            missed_r <= ~detected_nxt_s;
         end
      end
   end

   // Saturating statistics, updated on entry to INJECT and to REPORT so they are valid with done_o.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inject_count_r <= 16'd0;
         detect_count_r <= 16'd0;
         miss_count_r   <= 16'd0;
      end else begin
         if (inject_entry_s) begin
            inject_count_r <= sat_inc16(inject_count_r);
         end
         if (report_entry_s) begin
            if (detected_nxt_s) begin
               detect_count_r <= sat_inc16(detect_count_r);
            end else begin
               miss_count_r <= sat_inc16(miss_count_r);
            end
         end
      end
   end

endmodule
